onehot_hold_decoder: RTL
========================

// Module: onehot_hold_decoder
// PURPOSE
//   Receive-side counterpart of the 8-line priority encoder: accepts a 3-bit
//   code plus IDLE flag over a valid/ready handshake and re-expands it to a
//   registered one-hot 8-line output. Each decoded line is held for a fixed
//   number of cycles. Also keeps a running count of decoded (non-idle) beats.
// PARAMETERS
//   HOLD_CYCLES  4  cycles each decoded one-hot value is held; legal 1..255
//   CNT_W        8  width of beat counter out_count
// PORTS
//   clk          in   1      single clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   in_valid     in   1      code/idle beat present
//   in_ready     out  1      decoder can accept a beat this cycle
//   in_code      in   3      line index; bit 2 = MSB (encoder x1), bit 0 = x3
//   in_idle      in   1      encoder IDLE: no line asserted
//   out_onehot   out  8      bit k = line a_k asserted; at most one bit set
//   out_valid    out  1      out_onehot holds a decoded line
//   out_count    out  CNT_W  decoded non-idle beats, modulo 2^CNT_W
//   err_sticky   out  1      present only with DEC_ERRCHK_EN
// BEHAVIOUR
//   - Reset (async, any state): out_onehot=0, out_valid=0, out_count=0,
//     err_sticky=0, state=S_READY, hold counter=0. in_ready reads 1 after reset.
//   - States: S_READY (no output held), S_HOLD (line held, cnt counting down).
//   - in_ready = (state==S_READY) || (state==S_HOLD && cnt==0); combinational
//     from registers only, never from in_valid.
//   - Accept = in_valid && in_ready, sampled on the rising clk edge.
//   - Accept with in_idle=0: next cycle out_onehot=1<<in_code, out_valid=1,
//     cnt=HOLD_CYCLES-1, state=S_HOLD, out_count+=1 (wraps max->0).
//   - Accept with in_idle=1: out_onehot=0, out_valid=0, state=S_READY,
//     out_count unchanged. in_code is ignored.
//   - S_HOLD, no accept: cnt>0 -> cnt-=1, output held. cnt==0 -> out_onehot=0,
//     out_valid=0, state=S_READY.
//   - Latency: 1 cycle from accept to output. Non-idle output is held exactly
//     HOLD_CYCLES cycles.
//   - Back-to-back: an accept on the last hold cycle (cnt==0) loads the new
//     value directly, with no zero gap. Same code re-accepted restarts the hold.
//   - HOLD_CYCLES=1: in_ready stays 1 continuously. Each beat shows one cycle.
//   - in_valid=0 in S_READY: all outputs keep their values (0 / count).
//   - Reset asserted mid-hold: the hold is aborted immediately and the
//     in-flight beat is lost.
// CONFIGURATION
//   DEC_ERRCHK_EN defined: adds port err_sticky. It sets 1 the cycle after an
//     accept with in_idle=1 && in_code!=0. The beat is still treated as idle.
//     err_sticky clears only on rst.
//   DEC_ERRCHK_EN undefined: no err_sticky port and no check logic. An idle
//     beat with any in_code is silently treated as idle.
// TESTING
//   1. HOLD_CYCLES=4, accept code=5, idle=0 -> out_onehot=8'h20,
//      out_valid=1 for exactly cycles 1..4; in_ready=0 in cycles 1..3,
//      1 in cycle 4; out_count=1.
//   2. in_valid held with code 2, then code 7 -> 4 cycles of 8'h04,
//      then immediately 4 cycles of 8'h80 with no zero cycle; out_count=2.
//   3. Accept idle=1, code=0 in S_READY -> out_onehot=0, in_ready stays 1,
//      out_count unchanged.
//   4. rst pulsed during cycle 2 of a hold -> outputs 0 asynchronously;
//      in_ready=1 and out_count=0 after release.
//   5. HOLD_CYCLES=1, sweep codes 0..7 then 248 more beats -> out_onehot=1<<k
//      on each following cycle; out_count wraps to 0 after beat 256.
//   6. DEC_ERRCHK_EN: accept idle=1, code=3 -> err_sticky=1 next cycle and
//      stays 1 through later valid beats; out_onehot=0 for the bad beat.

Source files
------------

// File: rtl/onehot_hold_decoder.sv
// Re-expands a 3-bit code + IDLE beat into a held, registered one-hot line.
// Optional DEC_ERRCHK_EN adds err_sticky for idle beats carrying a code.
module onehot_hold_decoder #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_code,
    input  logic             in_idle,
    output logic [7:0]       out_onehot,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count
`ifdef DEC_ERRCHK_EN
    ,
    output logic             err_sticky
`endif
);

    typedef enum logic {
        S_READY,
        S_HOLD
    } state_t;

    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic [7:0]       onehot_n;
    logic             valid_n;
    logic [CNT_W-1:0] count_n;
    logic             accept;

    // Ready depends only on registered state so it never loops through in_valid
    assign in_ready = (state == S_READY) || (cnt == 8'd0);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        onehot_n = out_onehot;
        valid_n  = out_valid;
        count_n  = out_count;
        unique case (1'b1)
            accept && !in_idle: begin
                onehot_n = 8'd1 << in_code;
                valid_n  = 1'b1;
                cnt_n    = HOLD_LOAD;
                state_n  = S_HOLD;
                count_n  = out_count + CNT_ONE;
            end
            accept && in_idle: begin
                onehot_n = 8'd0;
                valid_n  = 1'b0;
                cnt_n    = 8'd0;
                state_n  = S_READY;
            end
            !accept && (state == S_HOLD) && (cnt != 8'd0): begin
                cnt_n = cnt - 8'd1;
            end
            !accept && (state == S_HOLD) && (cnt == 8'd0): begin
                onehot_n = 8'd0;
                valid_n  = 1'b0;
                state_n  = S_READY;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_READY;
            cnt        <= 8'd0;
            out_onehot <= 8'd0;
            out_valid  <= 1'b0;
            out_count  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            out_onehot <= onehot_n;
            out_valid  <= valid_n;
            out_count  <= count_n;
        end
    end

`ifdef DEC_ERRCHK_EN
    // Idle beats must carry code 0; anything else latches until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (accept && in_idle && (in_code != 3'd0)) begin
            err_sticky <= 1'b1;
        end
    end
`endif

endmodule
